// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with show-ahead read, occupancy count,
// programmable almost-full/almost-empty flags, synchronous flush and error pulses.
module param_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  input  logic                       push,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_ok, pop_ok;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign dout         = empty ? '0 : mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      overflow_d  = push & ~push_ok;
      underflow_d = pop & ~pop_ok;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: directed plan steps followed by random traffic, all
// checked against a queue-based model of the FIFO's accept rules.
module tb_param_fifo;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned AF_LEVEL = 3;
  localparam int unsigned AE_LEVEL = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             empty, full, almost_empty, almost_full;
  logic [2:0]       count;
  logic             overflow, underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  param_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .push(push), .pop(pop),
    .dout(dout), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned n;
    n = q.size();
    chk({tag, ".dout"},   32'(dout), (n > 0) ? 32'(q[0]) : 32'h0);
    chk({tag, ".count"},  32'(count), 32'(n));
    chk({tag, ".empty"},  32'(empty), 32'(n == 0));
    chk({tag, ".full"},   32'(full), 32'(n == DEPTH));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AE_LEVEL));
    chk({tag, ".afull"},  32'(almost_full), 32'(n >= AF_LEVEL));
    chk({tag, ".ovf"},    32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"},    32'(underflow), 32'(m_unf));
  endtask

  // Drive one cycle, advance the model at the edge, then compare just after it.
  task automatic step(input string tag, input logic p, input logic r,
                      input logic f, input logic [WIDTH-1:0] d);
    logic can_pop, can_push;
    push = p; pop = r; flush = f; din = d;
    @(posedge clk);
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      can_pop  = r && (q.size() > 0);
      can_push = p && ((q.size() < DEPTH) || can_pop);
      m_ovf = p && !can_push;
      m_unf = r && !can_pop;
      if (can_pop)  void'(q.pop_front());
      if (can_push) q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  initial begin
    // Reset then idle
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;
    step("idle", 0, 0, 0, 8'h00);

    // Fill to full, then overflow
    step("fill1", 1, 0, 0, 8'hA1);
    step("fill2", 1, 0, 0, 8'hA2);
    step("fill3", 1, 0, 0, 8'hA3);
    step("fill4", 1, 0, 0, 8'hA4);
    chk("full_at4", 32'(full), 32'h1);
    step("ovf", 1, 0, 0, 8'hB5);
    chk("ovf_pulse", 32'(overflow), 32'h1);
    step("ovf_clr", 0, 0, 0, 8'h00);
    chk("ovf_one_cycle", 32'(overflow), 32'h0);
    for (int i = 0; i < 4; i++) step("drain_a", 0, 1, 0, 8'h00);
    chk("drained_empty", 32'(empty), 32'h1);

    // Full with simultaneous push and pop, then drain across the wrap
    step("refill1", 1, 0, 0, 8'hA1);
    step("refill2", 1, 0, 0, 8'hA2);
    step("refill3", 1, 0, 0, 8'hA3);
    step("refill4", 1, 0, 0, 8'hA4);
    step("pushpop_full", 1, 1, 0, 8'hC0);
    chk("pp_dout_next", 32'(dout), 32'hA2);
    for (int i = 0; i < 4; i++) step("drain_b", 0, 1, 0, 8'h00);

    // Underflow cases
    step("unf", 0, 1, 0, 8'h00);
    chk("unf_pulse", 32'(underflow), 32'h1);
    step("pushpop_empty", 1, 1, 0, 8'h55);
    chk("pp_empty_dout", 32'(dout), 32'h55);
    step("unf_clr", 0, 0, 0, 8'h00);

    // Flush with push, three entries held
    step("pre_flush1", 1, 0, 0, 8'h11);
    step("pre_flush2", 1, 0, 0, 8'h22);
    step("flush", 1, 0, 1, 8'h33);
    chk("flush_empty", 32'(empty), 32'h1);

    // Asynchronous reset between edges with two entries
    step("pre_rst1", 1, 0, 0, 8'h77);
    step("pre_rst2", 1, 0, 0, 8'h88);
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_all("rst_held");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           logic'($urandom_range(0, 99) < 55),
           logic'($urandom_range(0, 99) < 45),
           logic'($urandom_range(0, 99) < 3),
           8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parametrised synchronous FIFO, the next generation of the 2-entry, 2-bit FIFO.
- Configurable width and power-of-two depth.
- Show-ahead read port, occupancy count, programmable almost-full/almost-empty flags.
- Synchronous flush, and overflow/underflow error pulses.
- Used as the standard elastic buffer between producer/consumer stages in the examples and their testbenches.

Parameters:
- WIDTH, 8, data width in bits; legal range ≥1.
- DEPTH, 4, number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: reset; one clock; reset is asynchronous and active-low.
- flush, in, 1: synchronous clear of contents.
- din, in, WIDTH: write data.
- push, in, 1: write request.
- pop, in, 1: read request; consumes the current dout.
- dout, out, WIDTH: head-of-queue data (show-ahead).
- empty, out, 1: count==0.
- full, out, 1: count==DEPTH.
- almost_empty, out, 1: count ≤ AE_LEVEL.
- almost_full, out, 1: count ≥ AF_LEVEL.
- count, out, log2(DEPTH)+1: current occupancy, 0..DEPTH.
- overflow, out, 1: one-cycle pulse on a rejected push.
- underflow, out, 1: one-cycle pulse on a rejected pop.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers=0, count=0, overflow=0, underflow=0.
  - empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 → never; AF_LEVEL ≥1 so 0).
  - dout=0. Storage array is not reset.
  - Deassertion takes effect at the next rising clk.
- State: rd_ptr and wr_ptr, log2(DEPTH) bits each, wrap modulo DEPTH naturally; count register of log2(DEPTH)+1 bits. All flags derive combinationally from count.
- dout = empty ? 0 : mem[rd_ptr]. Zero read latency: data written on edge N is visible on dout after edge N when the FIFO was empty.
- Accept rules, evaluated at the rising edge:
  - push_ok = push & (!full | pop_ok).
  - pop_ok = pop & !empty.
- push_ok: mem[wr_ptr] ← din, wr_ptr+1.
- pop_ok: rd_ptr+1.
- count update: +1 if push_ok only; −1 if pop_ok only; unchanged if both or neither.
- Full with push & pop: both accepted. Write lands in the slot being vacated; dout is the old head before the edge and the next entry after. Count stays DEPTH; overflow=0.
- Empty with push & pop: push accepted, pop rejected. Count becomes 1, underflow pulses, dout shows din after the edge.
- push while full without pop: data dropped, no state change, overflow=1 for the following cycle.
- pop while empty: no state change, underflow=1 for the following cycle.
- overflow and underflow are registered and cleared every cycle unless re-triggered.
- flush (synchronous, highest priority after reset):
  - Pointers and count → 0.
  - push and pop in the same cycle are ignored; no error pulses.
- Reset mid-operation: all contents are discarded immediately; outputs go to reset values without waiting for a clock.

Test Plan:
Use WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1 unless stated.
- Reset then idle → empty=1, full=0, count=0, almost_empty=1, almost_full=0, dout=0.
- Push 0xA1,0xA2,0xA3,0xA4 on consecutive edges → count 1,2,3,4; almost_empty drops at count 2; almost_full rises at count 3; full=1 at count 4; dout=0xA1 throughout.
- From full, push 0xB5 alone → overflow=1 for exactly one cycle, count stays 4. Then pop 4× → dout 0xA1,0xA2,0xA3,0xA4; empty=1; 0xB5 never appears.
- From full, push 0xC0 with pop on the same edge → count stays 4, full stays 1, no overflow. Pop 4× → dout 0xA2,0xA3,0xA4,0xC0 (verifies pointer wrap).
- From empty, pop alone → underflow pulse, count 0. Push 0x55 with pop on the same edge → count 1, dout=0x55, underflow=1 for one cycle.
- With 3 entries, assert flush with push=1 → count 0, empty=1, no overflow. Separately, assert rst low asynchronously between edges with 2 entries → count=0 and empty=1 before the next clk edge.
